hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage MIPS core. It compares D-stage register reads against E/M/W-stage writes using Tuse/Tnew. From that it produces the D-stage forwarding selects (the Forward_RS_D_src / Forward_RT_D_src inputs of the decode unit) and the StallF/StallD/ClearE controls. It also owns the multiply/divide busy sequencer, which stalls HI/LO-dependent instructions in D until the mult/div unit finishes.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu start (1..15)
DIV_CYCLES, 10, busy cycles after a div/divu start (1..15)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-low reset (Reset==0 resets)
RS_D  input  5  rs address of instruction in D
RT_D  input  5  rt address of instruction in D
Tuse_RS  input  2  cycles until rs is needed; 3 = not used
Tuse_RT  input  2  cycles until rt is needed; 3 = not used
A3_E  input  5  destination register of instruction in E (0 = none)
Tnew_E  input  2  cycles until E result is ready, as seen in E
Link_E  input  1  E instruction writes PC+8 (jal/jalr)
A3_M  input  5  destination register in M
Tnew_M  input  2  cycles until M result is ready
Link_M  input  1  M instruction writes PC+8
A3_W  input  5  destination register in W; W data is always ready
MD_Use_D  input  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
MD_Start_E  input  1  mult/div instruction valid in E this cycle
MD_Is_Div  input  1  qualifies MD_Start_E: 1 = div/divu
MD_Cancel  input  1  synchronous flush of the busy sequencer (exception)
StallF  output  1  hold PC
StallD  output  1  hold D pipeline register
ClearE  output  1  insert bubble into E
Forward_RS_D_src  output  3  rs forward select
Forward_RT_D_src  output  3  rt forward select
MD_Busy  output  1  mult/div unit busy

Behaviour:
- Forward select encoding: 0 = RF, 1 = PC4_E (link in E), 2 = AO (M ALU), 3 = PC4_M (link in M), 4 = WD of W.
- Per operand X (rs, rt), combinational, priority E > M > W:
  - X==0 -> 0.
  - X==A3_E && Tnew_E==0 && Link_E -> 1.
  - X==A3_M && Tnew_M==0 -> (Link_M ? 3 : 2).
  - X==A3_W -> 4.
  - else 0.
- A match against a stage whose result is not ready forwards nothing from a lower stage; that case is covered by the stall.
- Data stall for operand X (X!=0, Tuse_X!=3):
  - (X==A3_E && Tuse_X < Tnew_E), or
  - (X==A3_M && Tuse_X < Tnew_M).
- MD stall: MD_Use_D && MD_Busy.
- Stall = data stall on rs | data stall on rt | MD stall. StallF = StallD = ClearE = Stall, all combinational.
- MD sequencer: 4-bit down counter cnt; state IDLE (cnt==0) / BUSY (cnt!=0).
  - IDLE & MD_Start_E -> cnt <= MD_Is_Div ? DIV_CYCLES : MULT_CYCLES.
  - BUSY -> cnt <= cnt-1 each edge.
  - MD_Start_E while BUSY is ignored; it cannot occur legally because of the MD stall.
  - MD_Busy = MD_Start_E | (cnt!=0). A start is therefore busy for 1 + N cycles.
  - MD_Cancel (priority over start and decrement) -> cnt <= 0 next edge. MD_Busy still follows MD_Start_E combinationally in the cancel cycle.
- Reset (async, Reset==0): cnt=0, state IDLE. Outputs then follow inputs combinationally: MD_Busy=MD_Start_E; Stall/Forward per equations. Reset mid-BUSY aborts the count immediately.

Optional Feature:
HAZARD_STAT_EN
- Defined: extra output Stall_Cnt [31:0].
  - Increments on each rising edge where Stall==1; saturates at 32'hFFFFFFFF.
  - Async reset to 0.
  - Counts both data and MD stalls.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. lw $8 in E (A3_E=8, Tnew_E=2), D addu uses rs=8 (Tuse_RS=1) -> Stall=ClearE=1 for 1 cycle. Next cycle (A3_M=8, Tnew_M=1, Tuse=1) -> Stall=0; then with Tnew_M=0 -> Forward_RS_D_src=2.
2. beq rs=31 (Tuse_RS=0) with jal in E (A3_E=31, Tnew_E=0, Link_E=1) -> Forward_RS_D_src=1, no stall. Same in M with Link_M=1 -> select 3. Only A3_W=31 -> select 4.
3. rs=0 with A3_E=0, Tnew_E=2 -> no stall, select 0. Same reg matched in E (Tnew 0, non-link) and M (Tnew 0) -> select 2, since M is used when E is not forwardable.
4. MD_Start_E=1, MD_Is_Div=0 for one cycle, mflo in D (MD_Use_D=1) -> Stall=1 for exactly 6 cycles (start + 5), MD_Busy low on the 7th. With MD_Is_Div=1 -> 11 cycles.
5. div started, Reset pulsed low at cnt=4 -> MD_Busy=0 immediately. Separately, MD_Cancel at cnt=7 -> MD_Busy=0 from next cycle.
6. HAZARD_STAT_EN defined: run scenarios 1 and 4 back to back -> Stall_Cnt=7. Force Stall high with counter preset near max -> holds 32'hFFFFFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: D-stage hazard detection and forwarding control for the
// 5-stage MIPS pipeline, plus the mult/div busy sequencer.
//
// Ports:
//   Clk, Reset               clock (rising edge), async active-low reset
//   RS_D, RT_D               D-stage source register addresses
//   Tuse_RS, Tuse_RT         cycles until each source is needed (3 = unused)
//   A3_E/Tnew_E/Link_E       E-stage destination, readiness, link write
//   A3_M/Tnew_M/Link_M       M-stage destination, readiness, link write
//   A3_W                     W-stage destination (always ready)
//   MD_Use_D                 D instruction touches the mult/div unit or HI/LO
//   MD_Start_E, MD_Is_Div    mult/div start in E, and its kind
//   MD_Cancel                flush the busy sequencer
//   StallF, StallD, ClearE   pipeline stall/bubble controls (combinational)
//   Forward_RS_D_src/_RT_    D-stage forward selects (combinational)
//   MD_Busy                  mult/div unit busy (combinational)
//   Stall_Cnt                stall-cycle counter, present only when
//                            HAZARD_STAT_EN is defined
module hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  RS_D,
    input  logic [4:0]  RT_D,
    input  logic [1:0]  Tuse_RS,
    input  logic [1:0]  Tuse_RT,
    input  logic [4:0]  A3_E,
    input  logic [1:0]  Tnew_E,
    input  logic        Link_E,
    input  logic [4:0]  A3_M,
    input  logic [1:0]  Tnew_M,
    input  logic        Link_M,
    input  logic [4:0]  A3_W,
    input  logic        MD_Use_D,
    input  logic        MD_Start_E,
    input  logic        MD_Is_Div,
    input  logic        MD_Cancel,
    output logic        StallF,
    output logic        StallD,
    output logic        ClearE,
    output logic [2:0]  Forward_RS_D_src,
    output logic [2:0]  Forward_RT_D_src,
    output logic        MD_Busy
`ifdef HAZARD_STAT_EN
    ,
    output logic [31:0] Stall_Cnt
`endif
);

    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] FWD_RF    = 3'd0;
    localparam logic [2:0] FWD_PC4_E = 3'd1;
    localparam logic [2:0] FWD_AO_M  = 3'd2;
    localparam logic [2:0] FWD_PC4_M = 3'd3;
    localparam logic [2:0] FWD_WD_W  = 3'd4;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    md_state_t         md_state, md_state_nxt;
    logic [CNT_W-1:0]  md_cnt, md_cnt_nxt;
    logic              stall;

    // Forward select for one operand. The youngest stage writing the register
    // decides: if its value is not ready yet nothing older may be used.
    function automatic logic [2:0] fwd_sel(
        input logic [4:0] x,
        input logic [4:0] a3_e, input logic [1:0] tnew_e, input logic link_e,
        input logic [4:0] a3_m, input logic [1:0] tnew_m, input logic link_m,
        input logic [4:0] a3_w
    );
        logic [2:0] sel;
        sel = FWD_RF;
        if (x == 5'd0) begin
            sel = FWD_RF;
        end else if (x == a3_e && tnew_e != 2'd0) begin
            sel = FWD_RF;
        end else if (x == a3_e && link_e) begin
            sel = FWD_PC4_E;
        end else if (x == a3_m && tnew_m != 2'd0) begin
            sel = FWD_RF;
        end else if (x == a3_m) begin
            sel = link_m ? FWD_PC4_M : FWD_AO_M;
        end else if (x == a3_w) begin
            sel = FWD_WD_W;
        end
        return sel;
    endfunction

    // Operand needed before the producing stage can deliver it.
    function automatic logic data_stall(
        input logic [4:0] x, input logic [1:0] tuse,
        input logic [4:0] a3_e, input logic [1:0] tnew_e,
        input logic [4:0] a3_m, input logic [1:0] tnew_m
    );
        return (x != 5'd0) && (tuse != 2'd3) &&
               (((x == a3_e) && (tuse < tnew_e)) ||
                ((x == a3_m) && (tuse < tnew_m)));
    endfunction

    // Mult/div sequencer state register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            md_state <= MD_IDLE;
            md_cnt   <= '0;
        end else begin
            md_state <= md_state_nxt;
            md_cnt   <= md_cnt_nxt;
        end
    end

    // Sequencer next state; cancel overrides start and countdown.
    always_comb begin
        md_state_nxt = md_state;
        md_cnt_nxt   = md_cnt;
        case (md_state)
            MD_IDLE: begin
                if (MD_Start_E) begin
                    md_state_nxt = MD_BUSY;
                    md_cnt_nxt   = MD_Is_Div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            MD_BUSY: begin
                md_cnt_nxt = md_cnt - CNT_W'(1);
                if (md_cnt == CNT_W'(1)) begin
                    md_state_nxt = MD_IDLE;
                end
            end
            default: begin
                md_state_nxt = MD_IDLE;
                md_cnt_nxt   = '0;
            end
        endcase
        if (MD_Cancel) begin
            md_state_nxt = MD_IDLE;
            md_cnt_nxt   = '0;
        end
    end

    // Combinational hazard outputs.
    always_comb begin
        MD_Busy = MD_Start_E | (md_cnt != '0);
        stall   = data_stall(RS_D, Tuse_RS, A3_E, Tnew_E, A3_M, Tnew_M) |
                  data_stall(RT_D, Tuse_RT, A3_E, Tnew_E, A3_M, Tnew_M) |
                  (MD_Use_D & MD_Busy);
        StallF  = stall;
        StallD  = stall;
        ClearE  = stall;
        Forward_RS_D_src = fwd_sel(RS_D, A3_E, Tnew_E, Link_E, A3_M, Tnew_M, Link_M, A3_W);
        Forward_RT_D_src = fwd_sel(RT_D, A3_E, Tnew_E, Link_E, A3_M, Tnew_M, Link_M, A3_W);
    end

`ifdef HAZARD_STAT_EN
    // Saturating count of stalled cycles.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Stall_Cnt <= '0;
        end else if (stall && (Stall_Cnt != 32'hFFFF_FFFF)) begin
            Stall_Cnt <= Stall_Cnt + 32'd1;
        end
    end
`endif

endmodule
